input_read_scheduler: RTL
=========================

// Module: input_read_scheduler
// PURPOSE
//   Shares one source read port among NUM_CH input streams (e.g. ifmap, filter, psum-in), each feeding its own buffer.
//   Per channel, sequences read-request -> valid -> buffer-write handshake; round-robin arbitration with bursts of up to BURST words.
//   Sits between the source-side valid/r_en handshake and the per-channel buffer write ports (wen/full).
//   Guarantees at most one r_en and one wen high per cycle.
// PARAMETERS
//   NUM_CH  3  number of requesting channels (>=2)
//   BURST   4  max words written to one channel per grant before rotating (>=1)
//   IDX_W   $clog2(NUM_CH)  width of grant index (derived, not overridden)
// PORTS
//   clk       in   1       single clock, rising edge
//   rst       in   1       synchronous, active-high reset
//   ctrl_en   in   NUM_CH  per-channel enable from the top-level controller
//   full      in   NUM_CH  per-channel buffer full (reflects committed writes)
//   valid     in   NUM_CH  per-channel source data valid
//   r_en      out  NUM_CH  one-hot read request to granted source
//   wen       out  NUM_CH  one-hot buffer write strobe to granted channel
//   grant_idx out  IDX_W   granted channel; drives shared read-data mux
//   busy      out  1       high in any state other than ARB
// BEHAVIOUR
// - Reset: state=ARB, r_en=0, wen=0, grant_idx=0, busy=0, burst_cnt=0, last_grant=NUM_CH-1 (ch0 wins first).
// - Eligible[i] = ctrl_en[i] & ~full[i].
// - States: ARB, REQ, WRITE. Outputs Moore, decoded from state + grant_idx only.
//   ARB:  r_en=0, wen=0. Continue if burst_cnt in 1..BURST-1 and eligible[grant_idx]: keep grant, ->REQ.
//         Else burst_cnt<=0; pick first eligible searching last_grant+1, +2, ... (wrap at NUM_CH);
//         if found: grant_idx<=ch, last_grant<=ch, ->REQ; none eligible: stay ARB.
//   REQ:  r_en[grant_idx]=1. valid[grant_idx] -> WRITE.
//         ctrl_en[grant_idx] falls -> abort to ARB, no write, burst_cnt<=0.
//         Else stay REQ (no timeout). valid of other channels ignored.
//   WRITE: wen[grant_idx]=1 for exactly one cycle; burst_cnt<=burst_cnt+1; ->ARB unconditionally.
// - Latency: grant to first r_en 1 cycle; valid seen in REQ -> wen next cycle.
//   Min 3 cycles/word (ARB,REQ,WRITE); burst continuation also passes through ARB.
// - full sampled only in ARB, one cycle after the write commits; a buffer that fills on
//   word k ends the burst early and forces rotation.
// - burst_cnt width $clog2(BURST+1); on reaching BURST, next ARB rotates and clears it.
// - Single eligible channel: re-granted after each full burst (rotation falls back to it).
// - rst mid-REQ/WRITE: outputs 0 next cycle, no wen issued, arbitration restarts from ch0.
// - grant_idx holds its value in ARB when nothing is eligible (no glitch on the data mux).
// STRUCTURE
// - Shared header (isched_defs.vh): `define ISCHED_ARB/REQ/WRITE 2-bit encodings, default NUM_CH/BURST.
// - Sub-module rr_priority_picker #(NUM_CH): comb; inputs req[NUM_CH], last[IDX_W];
//   outputs found, idx — first set bit after last, wrapping.
// - Top: state reg, grant_idx/last_grant/burst_cnt regs, one-hot output decoders.
// TESTING
// 1 Reset: rst high 2 cycles with all ctrl_en=1 -> r_en=0, wen=0, busy=0; ctrl_en=3'b111 first grant ch0.
// 2 Burst/rotation: NUM_CH=3, BURST=4, all eligible, valid always 1 -> ch0 gets 4 wen, then ch1 x4,
//   ch2 x4, back to ch0; period 3 cycles/word; never two r_en/wen bits set.
// 3 Full mid-burst: full[1] rises after ch1's 2nd write -> ch1 gets exactly 2 wen, grant moves to ch2.
// 4 Valid stall: ch0 granted, valid[0] low 5 cycles -> r_en[0] held 5+ cycles, wen only cycle after valid.
// 5 Abort: ctrl_en[0] dropped while in REQ -> r_en clears, no wen[0], next grant ch1, burst_cnt=0.
// 6 Reset mid-op: rst pulsed in WRITE -> that wen suppressed, next grant ch0 regardless of last.

Source files
------------

// File: rtl/input_read_scheduler_pkg.sv
// Shared types and defaults for the input read scheduler: FSM state
// encoding, default channel/burst counts and width helpers.
package input_read_scheduler_pkg;

  // Two-bit state encoding. It is shared so that the top and any observers agree on it.
  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } isched_state_t;

  localparam int ISCHED_NUM_CH_DEFAULT = 3;
  localparam int ISCHED_BURST_DEFAULT  = 4;

  // The burst counter must be able to hold the value BURST itself, because
  // that terminal value is what forces the next ARB to rotate.
  function automatic int burst_cnt_width(input int burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

  // Index that follows v when counting modulo n. The picker walks the ring with it.
  function automatic int ring_next(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/input_read_scheduler_rr_priority_picker.sv
// Combinational round-robin picker. It returns the first set request bit
// after position 'last'. The search wraps around the ring, so 'last' itself
// is tried only after every other channel has been considered.
module rr_priority_picker
  import input_read_scheduler_pkg::*;
#(
  parameter int NUM_CH = ISCHED_NUM_CH_DEFAULT,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  // Walk last+1, last+2, ... with wrap, and keep the first hit.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = int'(last);
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ring_next(cand, NUM_CH);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/input_read_scheduler.sv
// Shares one source read port among NUM_CH input streams.
// For each word the FSM passes through three states:
//   ARB: pick a channel or continue the current burst.
//   REQ: hold r_en until the source raises valid.
//   WRITE: pulse wen for exactly one cycle.
// A grant lasts for up to BURST words before the grant rotates. Outputs are
// registered and mirror the state being entered, so r_en and wen are always
// one-hot or zero.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ARB   | idle/decision cycle, no strobes; continue burst or rotate
//   REQ   | r_en[grant_idx] held until valid[grant_idx] or ctrl_en drops
//   WRITE | wen[grant_idx] for one cycle, burst count advances
module input_read_scheduler
  import input_read_scheduler_pkg::*;
#(
  parameter int NUM_CH = ISCHED_NUM_CH_DEFAULT,
  parameter int BURST  = ISCHED_BURST_DEFAULT,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ctrl_en,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] r_en,
  output logic [NUM_CH-1:0] wen,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              busy
);

  localparam int CNT_W = burst_cnt_width(BURST);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

  isched_state_t      state;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   burst_cnt;

  logic [NUM_CH-1:0]  eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               burst_continue;

  // A channel may be served only when the controller enables it and its
  // buffer has room. Full is only consulted in ARB, after a write commits.
  always_comb begin
    eligible       = ctrl_en & ~full;
    burst_continue = (burst_cnt != '0) && (burst_cnt < BURST_MAX) &&
                     eligible[grant_idx];
  end

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (eligible),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Main sequencer. Each branch loads the outputs for the state it enters.
  // This keeps the outputs a pure function of the registered state and grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      grant_idx  <= '0;
      last_grant <= LAST_CH;
      burst_cnt  <= '0;
      r_en       <= '0;
      wen        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          wen <= '0;
          if (burst_continue) begin
            state <= ST_REQ;
            r_en  <= onehot(grant_idx);
            busy  <= 1'b1;
          end else begin
            burst_cnt <= '0;
            if (pick_found) begin
              grant_idx  <= pick_idx;
              last_grant <= pick_idx;
              state      <= ST_REQ;
              r_en       <= onehot(pick_idx);
              busy       <= 1'b1;
            end else begin
              // grant_idx is held here so the shared read-data mux stays put.
              r_en <= '0;
              busy <= 1'b0;
            end
          end
        end

        ST_REQ: begin
          // An enable that drops wins over a concurrent valid. The controller
          // has withdrawn the channel, so no data is written.
          if (!ctrl_en[grant_idx]) begin
            state     <= ST_ARB;
            burst_cnt <= '0;
            r_en      <= '0;
            wen       <= '0;
            busy      <= 1'b0;
          end else if (valid[grant_idx]) begin
            state <= ST_WRITE;
            r_en  <= '0;
            wen   <= onehot(grant_idx);
            busy  <= 1'b1;
          end else begin
            r_en <= onehot(grant_idx);
            wen  <= '0;
            busy <= 1'b1;
          end
        end

        ST_WRITE: begin
          state     <= ST_ARB;
          burst_cnt <= burst_cnt + CNT_W'(1);
          r_en      <= '0;
          wen       <= '0;
          busy      <= 1'b0;
        end

        default: begin
          state     <= ST_ARB;
          burst_cnt <= '0;
          r_en      <= '0;
          wen       <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
